// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue defaults and the {pc, instr} entry layout used by fetch and decode.
package fetch_queue_pkg;

  localparam int unsigned FQ_DATA_W     = 32;
  localparam int unsigned FQ_ADDR_W     = 32;
  localparam int unsigned FQ_DEPTH_LOG2 = 4;

  // One queued fetch record; pc occupies the upper bits, instr the lower bits.
  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_DATA_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch-queue storage: one synchronous write port, one asynchronous read port, no reset.
module fetch_queue_ram #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 64
) (
  input  logic                  clk_in,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the tail entry on an accepted push.
  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry is always visible at the read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between icache and dispatch with flush and global stall.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DATA_W     = FQ_DATA_W,
  parameter int unsigned ADDR_W     = FQ_ADDR_W,
  parameter int unsigned DEPTH_LOG2 = FQ_DEPTH_LOG2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_instr,
  input  logic [ADDR_W-1:0]     in_pc,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]     out_pc,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned PTR_W   = DEPTH_LOG2 + 1;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   count_q;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] rdata;

  // Pointer-derived flags; the MSB is the wrap bit.
  assign empty = (head == tail);
  assign full  = (head[PTR_W-1] != tail[PTR_W-1]) &&
                 (head[DEPTH_LOG2-1:0] == tail[DEPTH_LOG2-1:0]);

  // Handshakes are suppressed by reset, stall and flush; no pop-to-push forwarding when full.
  assign in_ready  = rdy_in && !rst_in && !flush_in && !full;
  assign out_valid = rdy_in && !rst_in && !flush_in && !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fetch_queue_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_ram (
    .clk_in (clk_in),
    .we     (push),
    .waddr  (tail[DEPTH_LOG2-1:0]),
    .wdata  ({in_pc, in_instr}),
    .raddr  (head[DEPTH_LOG2-1:0]),
    .rdata  (rdata)
  );

  assign {out_pc, out_instr} = rdata;
  assign count               = count_q;

  // Pointer and occupancy update: reset, then stall freeze, then flush, then push/pop.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + PTR_W'(1);
          2'b01:   count_q <= count_q - PTR_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (depth 4): vector table plus pc/instr scoreboard.
module tb_fetch_queue;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned DL = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush_in;
  logic          in_valid;
  logic [DW-1:0] in_instr;
  logic [AW-1:0] in_pc;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready;
  logic [DL:0]   count;

  fetch_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic        flush;
    logic        iv;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    int unsigned exp_cnt;
    string       name;
  } vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  vec_t          vecs[$];
  ent_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] next_pc = '0;

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] pc);
    return {pc[19:0], 12'h013};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic flush, input logic iv, input logic ordy,
                     input logic exp_ir, input logic exp_ov, input int unsigned exp_cnt,
                     input string name);
    vec_t v;
    v.rdy = rdy; v.flush = flush; v.iv = iv; v.ordy = ordy;
    v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_cnt = exp_cnt; v.name = name;
    vecs.push_back(v);
  endtask

  // Apply one cycle: check handshakes mid-cycle, update scoreboard, check count after the edge.
  task automatic step(input vec_t v);
    ent_t e;
    @(negedge clk_in);
    rst_in    = 1'b0;
    rdy_in    = v.rdy;
    flush_in  = v.flush;
    in_valid  = v.iv;
    out_ready = v.ordy;
    in_pc     = next_pc;
    in_instr  = instr_of(next_pc);
    #1;
    chk({v.name, ".in_ready"}, 64'(in_ready), 64'(v.exp_ir));
    chk({v.name, ".out_valid"}, 64'(out_valid), 64'(v.exp_ov));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk({v.name, ".pop_on_empty_model"}, 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk({v.name, ".out_pc"}, 64'(out_pc), 64'(e.pc));
        chk({v.name, ".out_instr"}, 64'(out_instr), 64'(e.instr));
      end
    end
    if (in_valid && in_ready) begin
      e.pc = in_pc;
      e.instr = in_instr;
      sb.push_back(e);
      next_pc = next_pc + 32'd4;
    end
    if (v.rdy && v.flush) sb.delete();
    @(posedge clk_in);
    #1;
    chk({v.name, ".count"}, 64'(count), 64'(v.exp_cnt));
    chk({v.name, ".count_vs_model"}, 64'(count), 64'(sb.size()));
  endtask

  task automatic do_reset(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_pc = 32'hDEAD_0000; in_instr = 32'h0;
      #1;
      chk({name, ".rst_in_ready"}, 64'(in_ready), 64'(0));
      chk({name, ".rst_out_valid"}, 64'(out_valid), 64'(0));
      @(posedge clk_in);
      #1;
      chk({name, ".rst_count"}, 64'(count), 64'(0));
    end
    sb.delete();
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b0; flush_in = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_pc = '0; in_instr = '0;

    do_reset(2, "reset");

    // Fill to full, then try a fifth push.
    add(1, 0, 1, 0, 1, 0, 1, "fill1");
    add(1, 0, 1, 0, 1, 1, 2, "fill2");
    add(1, 0, 1, 0, 1, 1, 3, "fill3");
    add(1, 0, 1, 0, 1, 1, 4, "fill4");
    add(1, 0, 1, 0, 0, 1, 4, "fill5_reject");
    // Drain in order.
    add(1, 0, 0, 1, 0, 1, 3, "drain1");
    add(1, 0, 0, 1, 1, 1, 2, "drain2");
    add(1, 0, 0, 1, 1, 1, 1, "drain3");
    add(1, 0, 0, 1, 1, 1, 0, "drain4");
    add(1, 0, 0, 1, 1, 0, 0, "drain_empty");
    // Concurrent push/pop at count 2 across pointer wrap.
    add(1, 0, 1, 0, 1, 0, 1, "wrap_pre1");
    add(1, 0, 1, 0, 1, 1, 2, "wrap_pre2");
    for (int i = 0; i < 10; i++) add(1, 0, 1, 1, 1, 1, 2, $sformatf("wrap%0d", i));
    // Flush at count 3 with push and pop requested.
    add(1, 0, 1, 0, 1, 1, 3, "flush_pre");
    add(1, 1, 1, 1, 0, 0, 0, "flush");
    add(1, 0, 0, 0, 1, 0, 0, "flush_after");
    // Stall at count 2.
    add(1, 0, 1, 0, 1, 0, 1, "stall_pre1");
    add(1, 0, 1, 0, 1, 1, 2, "stall_pre2");
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 0, 2, $sformatf("stall%0d", i));
    add(1, 0, 1, 1, 1, 1, 2, "stall_resume");
    add(1, 0, 0, 1, 1, 1, 1, "stall_drain1");
    add(1, 0, 0, 1, 1, 1, 0, "stall_drain2");

    foreach (vecs[i]) step(vecs[i]);

    // Empty no-bypass: pushed word appears only on the next cycle.
    begin
      vec_t v;
      next_pc = 32'h100;
      v = '{rdy: 1, flush: 0, iv: 1, ordy: 0, exp_ir: 1, exp_ov: 0, exp_cnt: 1, name: "nobyp_push"};
      step(v);
      chk("nobyp.out_valid_next", 64'(out_valid), 64'(1));
      chk("nobyp.out_pc_next", 64'(out_pc), 64'(32'h100));
      v = '{rdy: 1, flush: 0, iv: 0, ordy: 1, exp_ir: 1, exp_ov: 1, exp_cnt: 0, name: "nobyp_pop"};
      step(v);
    end

    // Reset mid-stream discards entries.
    begin
      vec_t v;
      v = '{rdy: 1, flush: 0, iv: 1, ordy: 0, exp_ir: 1, exp_ov: 0, exp_cnt: 1, name: "midrst_a"};
      step(v);
      v = '{rdy: 1, flush: 0, iv: 1, ordy: 0, exp_ir: 1, exp_ov: 1, exp_cnt: 2, name: "midrst_b"};
      step(v);
      do_reset(1, "midrst");
      v = '{rdy: 1, flush: 0, iv: 0, ordy: 1, exp_ir: 1, exp_ov: 0, exp_cnt: 0, name: "midrst_after"};
      step(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction queue between the instruction cache and the decode/dispatch stage. It buffers fetched instruction words with their PCs in a circular FIFO of configurable depth and width, and presents them to dispatch with a valid/ready handshake. It supports a single-cycle flush on branch mispredict or ROB rollback, and stalls globally on `rdy_in`.

## Interface
- `DATA_W`, 32: instruction word width in bits.
- `ADDR_W`, 32: PC width in bits.
- `DEPTH_LOG2`, 4: log2 of queue depth. Depth = 2^DEPTH_LOG2 entries; minimum 1.

- `clk_in`  in  1  single clock, all state updates on rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global enable; low freezes all state.
- `flush_in`  in  1  discard all entries (mispredict / ROB clear).
- `in_valid`  in  1  icache presents a word this cycle.
- `in_instr`  in  DATA_W  fetched instruction.
- `in_pc`  in  ADDR_W  PC of `in_instr`.
- `in_ready`  out  1  queue accepts a word this cycle.
- `out_valid`  out  1  head entry is presented to dispatch.
- `out_instr`  out  DATA_W  head instruction.
- `out_pc`  out  ADDR_W  head PC.
- `out_ready`  in  1  dispatch takes the head (ROB/RS not full).
- `count`  out  DEPTH_LOG2+1  registered occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {pc, instr}. Head and tail pointers are DEPTH_LOG2+1 bits; the MSB is a wrap bit.
  - Empty when the pointers are equal.
  - Full when the pointers differ only in the MSB.
- Push: `in_valid && in_ready`. Writes {in_pc, in_instr} at tail; tail increments modulo 2^(DEPTH_LOG2+1).
- Pop: `out_valid && out_ready`. Head increments.
- Combinational handshakes:
  - `in_ready = rdy_in && !rst_in && !flush_in && !full`
  - `out_valid = rdy_in && !rst_in && !flush_in && !empty`
- No bypass: a word pushed into an empty queue is visible at the output on the next cycle.
- No pop-to-push forwarding: when full, `in_ready` stays 0 even if a pop occurs the same cycle.
- Simultaneous push and pop (neither full nor empty): both take effect; `count` is unchanged.
- `count` update: +1 on push only, −1 on pop only, unchanged otherwise.
- Flush (`flush_in=1`, `rdy_in=1`):
  - Head, tail and count go to 0 on the next edge.
  - A same-cycle push or pop is not performed, because both handshakes are forced low.
- Priority: `rst_in` > `!rdy_in` (freeze) > `flush_in` > push/pop.
- `out_instr`/`out_pc` always show the storage entry at head. Their value is don't-care when `out_valid=0`.
- Storage contents are not cleared by reset or flush.

## Timing
- Reset (`rst_in=1` at an edge): head=0, tail=0, count=0.
  - During reset cycles, `in_ready=0` and `out_valid=0`.
  - After reset: `in_ready=1` and `out_valid=0` in the first cycle with `rdy_in=1`.
- Push-to-pop latency: 1 cycle minimum.
- Throughput: one push and one pop per cycle.
- Reset or flush mid-stream: all in-flight entries are lost; no partial state is retained.
- `rdy_in` low: no pointer or count change. Handshakes read 0, so upstream and downstream must hold their data.
- Wrap-around: pointer increments past DEPTH−1 roll to index 0 and toggle the MSB. Ordering is preserved across the wrap.

## Structure
- Shared package (header):
  - default instruction width (32)
  - default PC width (32)
  - default queue depth log2 (4)
  - the {pc, instr} entry field layout, reused by decode.
- Sub-module `fetch_queue_ram`:
  - DEPTH×(ADDR_W+DATA_W) array
  - one synchronous write port and one asynchronous read port
  - no reset.
- Pointer, flag and count logic live in `fetch_queue`.

## Test plan
- **Reset then fill:** DEPTH_LOG2=2; push instr 0x00000013 (pc 0x0, 0x4, … 0xC).
  - After the 4th push, `in_ready=0` and `count=4`.
  - A 5th `in_valid` is not accepted.
- **Drain order:** from full, hold `out_ready=1`.
  - Outputs are pc 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - `out_valid` drops and `count=0` after the last pop.
- **Concurrent push/pop with wrap:** with count=2, push and pop every cycle for 10 cycles.
  - `count` stays 2.
  - Output PCs are strictly sequential across the pointer wrap.
- **Flush:** with count=3, assert `flush_in` together with `in_valid` and `out_ready`.
  - Next cycle: `count=0`, `out_valid=0`.
  - The flushed-cycle word is not stored.
- **Stall:** with count=2, hold `rdy_in=0` for 3 cycles while `in_valid=out_ready=1`.
  - `count` stays 2; `in_ready` and `out_valid` read 0.
  - Normal flow resumes on the first cycle `rdy_in=1`.
- **Empty no-bypass:** push pc 0x100 into an empty queue.
  - `out_valid=0` in the same cycle.
  - `out_valid=1` with `out_pc=0x100` next cycle.
